// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_BUSY = 2'd1
  } ctrl_state_t;

  // Register specifier 0 is hardwired zero and never creates a dependency
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic pc_write;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_flush;
    logic exmem_hold;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_vec_t;

  // Everything quiet: used while in reset and as the base for stall rows
  localparam ctrl_vec_t CTRL_NONE = '{pc_write: 1'b0, ifid_hold: 1'b0, ifid_flush: 1'b0,
                                      idex_hold: 1'b0, idex_flush: 1'b0, exmem_hold: 1'b0,
                                      exmem_flush: 1'b0, memwb_flush: 1'b0};

  // Free-running pipeline: only the PC advances, no register is held or flushed
  localparam ctrl_vec_t CTRL_RUN = '{pc_write: 1'b1, ifid_hold: 1'b0, ifid_flush: 1'b0,
                                     idex_hold: 1'b0, idex_flush: 1'b0, exmem_hold: 1'b0,
                                     exmem_flush: 1'b0, memwb_flush: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use dependency comparator between EX and ID
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  load_use
);

  logic dest_live;
  logic rs_match;
  logic rt_match;

  assign dest_live = ex_valid && ex_is_load && (ex_dest != REG_ADDR_W'(REG_ZERO));
  assign rs_match  = (ex_dest == id_rs);
  assign rt_match  = id_uses_rt && (ex_dest == id_rt);
  assign load_use  = dest_live && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRt,
  input  logic                  EX_Valid,
  input  logic                  EX_IsLoad,
  input  logic [REG_ADDR_W-1:0] EX_Dest,
  input  logic                  EX_BranchTaken,
  input  logic                  EX_MulStart,
  input  logic                  MEM_Req,
  input  logic                  MEM_Ack,
  input  logic                  StallCountClear,
  output logic                  PC_Write,
  output logic                  IFID_Hold,
  output logic                  IFID_Flush,
  output logic                  IDEX_Hold,
  output logic                  IDEX_Flush,
  output logic                  EXMEM_Hold,
  output logic                  EXMEM_Flush,
  output logic                  MEMWB_Flush,
  output logic [1:0]            Ctrl_State,
  output logic [CNT_W-1:0]      StallCount,
  output logic                  MemTimeout
);

  // A single-cycle multiply never enters MUL_BUSY
  localparam bit MUL_MULTI = (MUL_LATENCY > 1);
  // cnt holds at most MUL_LATENCY-2
  localparam int MC_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
  localparam logic [MC_W-1:0] CNT_LOAD = MC_W'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t     state;
  logic [MC_W-1:0] mul_cnt;
  logic [WC_W-1:0] wait_cnt;
  ctrl_vec_t       ctrl;
  logic            mem_wait;
  logic            load_use;
  logic            mul_stall;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .ex_valid   (EX_Valid),
    .ex_is_load (EX_IsLoad),
    .ex_dest    (EX_Dest),
    .id_rs      (ID_Rs),
    .id_rt      (ID_Rt),
    .id_uses_rt (ID_UsesRt),
    .load_use   (load_use)
  );

  assign mem_wait  = MEM_Req && !MEM_Ack;
  assign mul_stall = ((state == ST_RUN) && EX_MulStart && MUL_MULTI) ||
                     ((state == ST_MUL_BUSY) && (mul_cnt != '0));

  // Priority-ordered control vector; everything is quiet while reset is asserted
  always_comb begin
    ctrl = CTRL_NONE;
    if (reset) begin
      if (mem_wait) begin
        ctrl.ifid_hold   = 1'b1;
        ctrl.idex_hold   = 1'b1;
        ctrl.exmem_hold  = 1'b1;
        ctrl.memwb_flush = 1'b1;
      end else if (mul_stall) begin
        ctrl.ifid_hold   = 1'b1;
        ctrl.idex_hold   = 1'b1;
        ctrl.exmem_flush = 1'b1;
      end else if (EX_BranchTaken) begin
        ctrl.pc_write    = 1'b1;
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_flush  = 1'b1;
      end else if (load_use) begin
        ctrl.ifid_hold   = 1'b1;
        ctrl.idex_flush  = 1'b1;
      end else begin
        ctrl = CTRL_RUN;
      end
    end
  end

  assign PC_Write    = ctrl.pc_write;
  assign IFID_Hold   = ctrl.ifid_hold;
  assign IFID_Flush  = ctrl.ifid_flush;
  assign IDEX_Hold   = ctrl.idex_hold;
  assign IDEX_Flush  = ctrl.idex_flush;
  assign EXMEM_Hold  = ctrl.exmem_hold;
  assign EXMEM_Flush = ctrl.exmem_flush;
  assign MEMWB_Flush = ctrl.memwb_flush;
  assign Ctrl_State  = state;

  // Multiply occupancy FSM; a memory wait freezes it so the multiply resumes where it stopped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_RUN;
      mul_cnt <= '0;
    end else if (!mem_wait) begin
      case (state)
        ST_RUN: begin
          if (EX_MulStart && MUL_MULTI) begin
            mul_cnt <= CNT_LOAD;
            state   <= ST_MUL_BUSY;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_cnt != '0) begin
            mul_cnt <= mul_cnt - MC_W'(1);
          end else begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
    end else if (StallCountClear) begin
      StallCount <= '0;
    end else if (!ctrl.pc_write && (StallCount != '1)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

  // Consecutive memory-wait counter with a sticky timeout flag; the stall itself is not released
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt != WC_W'(MEM_TIMEOUT)) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end
      if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
        MemTimeout <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int REG_ADDR_W  = 5;
  localparam int MUL_LATENCY = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 16;

  // {PC_Write, IFID_Hold, IFID_Flush, IDEX_Hold, IDEX_Flush, EXMEM_Hold, EXMEM_Flush, MEMWB_Flush}
  localparam logic [7:0] V_NONE = 8'b0000_0000;
  localparam logic [7:0] V_RUN  = 8'b1000_0000;
  localparam logic [7:0] V_MEMW = 8'b0101_0101;
  localparam logic [7:0] V_MUL  = 8'b0101_0010;
  localparam logic [7:0] V_BR   = 8'b1010_1000;
  localparam logic [7:0] V_LU   = 8'b0100_1000;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [REG_ADDR_W-1:0] ID_Rs = '0;
  logic [REG_ADDR_W-1:0] ID_Rt = '0;
  logic                  ID_UsesRt = 1'b0;
  logic                  EX_Valid = 1'b0;
  logic                  EX_IsLoad = 1'b0;
  logic [REG_ADDR_W-1:0] EX_Dest = '0;
  logic                  EX_BranchTaken = 1'b0;
  logic                  EX_MulStart = 1'b0;
  logic                  MEM_Req = 1'b0;
  logic                  MEM_Ack = 1'b0;
  logic                  StallCountClear = 1'b0;
  logic                  PC_Write;
  logic                  IFID_Hold;
  logic                  IFID_Flush;
  logic                  IDEX_Hold;
  logic                  IDEX_Flush;
  logic                  EXMEM_Hold;
  logic                  EXMEM_Flush;
  logic                  MEMWB_Flush;
  logic [1:0]            Ctrl_State;
  logic [CNT_W-1:0]      StallCount;
  logic                  MemTimeout;

  int checks = 0;
  int failures = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (REG_ADDR_W),
    .MUL_LATENCY (MUL_LATENCY),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ID_Rs           (ID_Rs),
    .ID_Rt           (ID_Rt),
    .ID_UsesRt       (ID_UsesRt),
    .EX_Valid        (EX_Valid),
    .EX_IsLoad       (EX_IsLoad),
    .EX_Dest         (EX_Dest),
    .EX_BranchTaken  (EX_BranchTaken),
    .EX_MulStart     (EX_MulStart),
    .MEM_Req         (MEM_Req),
    .MEM_Ack         (MEM_Ack),
    .StallCountClear (StallCountClear),
    .PC_Write        (PC_Write),
    .IFID_Hold       (IFID_Hold),
    .IFID_Flush      (IFID_Flush),
    .IDEX_Hold       (IDEX_Hold),
    .IDEX_Flush      (IDEX_Flush),
    .EXMEM_Hold      (EXMEM_Hold),
    .EXMEM_Flush     (EXMEM_Flush),
    .MEMWB_Flush     (MEMWB_Flush),
    .Ctrl_State      (Ctrl_State),
    .StallCount      (StallCount),
    .MemTimeout      (MemTimeout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      assert (!(EX_MulStart && EX_BranchTaken)) else begin
        failures++;
        $error("FAIL illegal_mul_branch observed=1 expected=0");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_obs();
    return {PC_Write, IFID_Hold, IFID_Flush, IDEX_Hold, IDEX_Flush,
            EXMEM_Hold, EXMEM_Flush, MEMWB_Flush};
  endfunction

  task automatic check_out();
    logic [9:0] e;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_ctrl"}, {24'd0, ctrl_obs()}, {24'd0, e[9:2]});
    chk({t, "_state"}, {30'd0, Ctrl_State}, {30'd0, e[1:0]});
  endtask

  // Inputs are already driven (at a falling edge); record expectation, compare, then clock once
  task automatic step(input string tag, input logic [7:0] ev, input logic [1:0] es);
    exp_q.push_back({ev, es});
    tag_q.push_back(tag);
    #1;
    check_out();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0;
    EX_Valid = 1'b0; EX_IsLoad = 1'b0; EX_Dest = '0;
    EX_BranchTaken = 1'b0; EX_MulStart = 1'b0;
    MEM_Req = 1'b0; MEM_Ack = 1'b0; StallCountClear = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses_rt);
    EX_Valid = 1'b1; EX_IsLoad = 1'b1; EX_Dest = dest;
    ID_Rs = rs; ID_Rt = rt; ID_UsesRt = uses_rt;
  endtask

  initial begin
    #2;
    chk("rst_ctrl", {24'd0, ctrl_obs()}, {24'd0, V_NONE});
    chk("rst_state", {30'd0, Ctrl_State}, 32'd0);
    chk("rst_sc", {16'd0, StallCount}, 32'd0);
    chk("rst_to", {31'd0, MemTimeout}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    step("idle", V_RUN, 2'd0);
    chk("sc_idle", {16'd0, StallCount}, 32'd0);

    // load-use on rs, then dest 0, then rt dependency with and without UsesRt
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    step("lu_rs", V_LU, 2'd0);
    chk("sc_lu", {16'd0, StallCount}, 32'd1);
    set_load(5'd0, 5'd0, 5'd0, 1'b1);
    step("lu_zero", V_RUN, 2'd0);
    chk("sc_lu_zero", {16'd0, StallCount}, 32'd1);
    set_load(5'd7, 5'd3, 5'd7, 1'b1);
    step("lu_rt", V_LU, 2'd0);
    set_load(5'd7, 5'd3, 5'd7, 1'b0);
    step("lu_rt_unused", V_RUN, 2'd0);
    chk("sc_lu_rt", {16'd0, StallCount}, 32'd2);

    // clear beats increment
    set_load(5'd9, 5'd9, 5'd0, 1'b0);
    StallCountClear = 1'b1;
    step("lu_clr", V_LU, 2'd0);
    chk("sc_clr", {16'd0, StallCount}, 32'd0);
    idle_inputs();

    // four-cycle multiply
    EX_MulStart = 1'b1;
    step("mul0", V_MUL, 2'd0);
    step("mul1", V_MUL, 2'd1);
    step("mul2", V_MUL, 2'd1);
    step("mul_rel", V_RUN, 2'd1);
    EX_MulStart = 1'b0;
    chk("mul_state_after", {30'd0, Ctrl_State}, 32'd0);
    chk("sc_mul", {16'd0, StallCount}, 32'd3);

    // memory wait masks a taken branch until the ack cycle
    EX_BranchTaken = 1'b1; MEM_Req = 1'b1;
    for (int i = 0; i < 3; i++) step("memw_br", V_MEMW, 2'd0);
    MEM_Ack = 1'b1;
    step("memw_ack_br", V_BR, 2'd0);
    chk("sc_memw", {16'd0, StallCount}, 32'd6);
    chk("to_memw3", {31'd0, MemTimeout}, 32'd0);
    idle_inputs();

    // branch wins over load-use
    EX_BranchTaken = 1'b1;
    set_load(5'd4, 5'd4, 5'd0, 1'b0);
    step("br_lu", V_BR, 2'd0);
    chk("sc_br_lu", {16'd0, StallCount}, 32'd6);
    idle_inputs();

    // memory wait while MUL_BUSY with one decrement left freezes the multiply
    EX_MulStart = 1'b1;
    step("mw_mul0", V_MUL, 2'd0);
    step("mw_mul1", V_MUL, 2'd1);
    MEM_Req = 1'b1;
    step("mw_wait0", V_MEMW, 2'd1);
    step("mw_wait1", V_MEMW, 2'd1);
    MEM_Req = 1'b0;
    step("mw_mul2", V_MUL, 2'd1);
    step("mw_rel", V_RUN, 2'd1);
    EX_MulStart = 1'b0;
    step("mw_after", V_RUN, 2'd0);
    chk("sc_mw", {16'd0, StallCount}, 32'd11);

    // timeout after the fourth consecutive wait cycle, sticky past the ack
    MEM_Req = 1'b1;
    for (int i = 0; i < 3; i++) step("to_wait", V_MEMW, 2'd0);
    chk("to_before", {31'd0, MemTimeout}, 32'd0);
    step("to_wait4", V_MEMW, 2'd0);
    chk("to_set", {31'd0, MemTimeout}, 32'd1);
    MEM_Ack = 1'b1;
    step("to_ack", V_RUN, 2'd0);
    chk("to_sticky", {31'd0, MemTimeout}, 32'd1);
    chk("sc_to", {16'd0, StallCount}, 32'd15);
    idle_inputs();

    // asynchronous reset in the middle of a multiply
    EX_MulStart = 1'b1;
    step("rst_mul0", V_MUL, 2'd0);
    chk("rst_mul_busy", {30'd0, Ctrl_State}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_state", {30'd0, Ctrl_State}, 32'd0);
    chk("arst_sc", {16'd0, StallCount}, 32'd0);
    chk("arst_to", {31'd0, MemTimeout}, 32'd0);
    chk("arst_ctrl", {24'd0, ctrl_obs()}, {24'd0, V_NONE});
    idle_inputs();
    @(negedge clock);
    reset = 1'b1;
    step("post_rst", V_RUN, 2'd0);
    chk("post_rst_sc", {16'd0, StallCount}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline.
- Watches ID/EX operand registers, EX branch resolution, the EX multi-cycle multiply and the MEM memory handshake.
- Drives per-register hold/flush enables for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC write enable.
- A flushed pipeline register loads all-zero (the NOP / reset image); a held register keeps its value.

Parameters:
REG_ADDR_W, 5, register specifier width
MUL_LATENCY, 4, total cycles a multiply occupies EX (>=1)
MEM_TIMEOUT, 255, consecutive memory-wait cycles before MemTimeout is flagged (>=1)
CNT_W, 16, stall-cycle counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
ID_Rs  in  REG_ADDR_W  rs of instruction in ID
ID_Rt  in  REG_ADDR_W  rt of instruction in ID
ID_UsesRt  in  1  ID instruction reads rt
EX_Valid  in  1  EX holds a real (non-bubble) instruction
EX_IsLoad  in  1  EX instruction is a load
EX_Dest  in  REG_ADDR_W  EX destination register
EX_BranchTaken  in  1  branch/jump resolved taken in EX
EX_MulStart  in  1  EX holds a multiply
MEM_Req  in  1  MEM stage is accessing memory
MEM_Ack  in  1  memory completes access this cycle
StallCountClear  in  1  synchronous clear of StallCount
PC_Write  out  1  PC may update
IFID_Hold  out  1
IFID_Flush  out  1
IDEX_Hold  out  1
IDEX_Flush  out  1
EXMEM_Hold  out  1
EXMEM_Flush  out  1
MEMWB_Flush  out  1
Ctrl_State  out  2  0=RUN, 1=MUL_BUSY
StallCount  out  CNT_W  cycles with PC_Write=0, saturating
MemTimeout  out  1  sticky memory-timeout error

Behaviour:
- Reset: one clock `clock`; reset `reset` is asynchronous and active-low.
  - While reset=0: state=RUN, mul counter=0, StallCount=0, MemTimeout=0, wait counter=0.
  - While reset=0, all hold/flush outputs=0 and PC_Write=0.
  - Reset mid-multiply abandons the multiply immediately.
- Control outputs are combinational from state and inputs (zero latency). State and counters update on the rising edge.
- Derived terms:
  - MemWait = MEM_Req & ~MEM_Ack.
  - LoadUse = EX_Valid & EX_IsLoad & (EX_Dest!=0) & ((EX_Dest==ID_Rs) | (ID_UsesRt & EX_Dest==ID_Rt)).
  - MulStall = (RUN & EX_MulStart & MUL_LATENCY>1) | (MUL_BUSY & cnt!=0).
- Priority, highest first; the first matching row sets all outputs, and unlisted outputs are 0:
  1. MemWait: PC_Write=0, IFID_Hold, IDEX_Hold, EXMEM_Hold, MEMWB_Flush=1. EX_BranchTaken and LoadUse are ignored; EX is frozen and re-evaluates later.
  2. MulStall: PC_Write=0, IFID_Hold, IDEX_Hold, EXMEM_Flush=1.
  3. EX_BranchTaken: PC_Write=1, IFID_Flush, IDEX_Flush=1. Branch beats LoadUse because the ID instruction is wrong-path.
  4. LoadUse: PC_Write=0, IFID_Hold=1, IDEX_Flush=1.
  5. Otherwise: PC_Write=1.
- FSM (edge updates suppressed entirely while MemWait=1; state and cnt freeze):
  - RUN: if EX_MulStart & MUL_LATENCY>1, load cnt=MUL_LATENCY-2 and go to MUL_BUSY.
  - MUL_BUSY:
    - cnt!=0: decrement cnt, stay.
    - cnt==0: this is the release cycle. No mul stall, the multiply advances, EX_MulStart is ignored, and the FSM returns to RUN.
  - Total EX occupancy is exactly MUL_LATENCY cycles, excluding MemWait cycles.
- StallCount:
  - +1 on each edge where PC_Write=0; saturates at all-ones.
  - StallCountClear wins over increment and loads 0.
- MemTimeout:
  - A wait counter increments on each MemWait cycle and clears when MemWait=0.
  - When it reaches MEM_TIMEOUT, MemTimeout sets and stays set until reset.
  - The stall itself is not released; memory must still ack.
- EX_MulStart and EX_BranchTaken simultaneous: illegal. The bench asserts it never occurs; if it does, the priority order above holds.

Decomposition:
- Package pipeline_ctrl_pkg:
  - State encoding RUN/MUL_BUSY.
  - REG_ZERO constant.
  - A struct or constant for the default (run) control vector.
- One natural sub-module: hazard_detect (combinational LoadUse comparator). It is reusable for a later forwarding unit.

Test Plan:
- Load-use: EX_Valid=1, EX_IsLoad=1, EX_Dest=5, ID_Rs=5 for 1 cycle -> PC_Write=0, IFID_Hold=1, IDEX_Flush=1, StallCount 0->1. Repeat with EX_Dest=0 -> no stall.
- Multiply, MUL_LATENCY=4: EX_MulStart held -> stalls on cycles 0,1,2 (Ctrl_State 0,1,1), release on cycle 3 with Ctrl_State=1->0, EXMEM_Flush=1 on the 3 stall cycles only, StallCount=3.
- Memory wait: MEM_Req=1, MEM_Ack=0 for 3 cycles then Ack=1, with EX_BranchTaken=1 throughout -> 3 cycles of EXMEM_Hold/MEMWB_Flush, no IFID_Flush. On the ack cycle, IFID_Flush=IDEX_Flush=1 and PC_Write=1.
- Branch plus load-use in the same cycle -> IFID_Flush=IDEX_Flush=1, PC_Write=1, IFID_Hold=0.
- MemWait arriving in MUL_BUSY with cnt=1 for 2 cycles -> cnt stays 1. Total stall = 3 mul + 2 mem cycles.
- Timeout and reset:
  - MEM_TIMEOUT=4, with memory never acking -> MemTimeout=1 after 4th wait cycle, still set after Ack.
  - reset=0 mid-MUL_BUSY -> Ctrl_State=0, StallCount=0, MemTimeout=0 immediately (asynchronous).
